// File: rtl/arch_rat_multi_retire.sv
// Retirement-side register alias table: multi-wide commit with superseded-tag release
// and a sequencer that streams the committed map to the front-end RAT on recovery.

module arch_rat_slot #(
    parameter int ARCH_REGS      = 32,
    parameter int PHY_WIDTH      = 6,
    parameter int ZERO_REG_FIXED = 1
) (
    input  logic                                 accept,
    input  logic [4:0]                           rd_arch,
    input  logic [PHY_WIDTH-1:0]                 rd_phy,
    input  logic [ARCH_REGS-1:0][PHY_WIDTH-1:0]  map_in,
    output logic [ARCH_REGS-1:0][PHY_WIDTH-1:0]  map_out,
    output logic                                 free_en,
    output logic [PHY_WIDTH-1:0]                 old_phy
);
    // One commit slot: reads the map as left by older slots, so same-cycle WAW chains naturally.
    always_comb begin
        map_out = map_in;
        old_phy = '0;
        free_en = accept && !((ZERO_REG_FIXED != 0) && (rd_arch == 5'd0));
        for (int i = 0; i < ARCH_REGS; i++) begin
            if (rd_arch == 5'(i)) begin
                old_phy = map_in[i];
                if (free_en)
                    map_out[i] = rd_phy;
            end
        end
    end
endmodule

module arch_rat_multi_retire #(
    parameter int ARCH_REGS      = 32,
    parameter int PHY_WIDTH      = 6,
    parameter int RETIRE_WIDTH   = 2,
    parameter int LANES          = 8,
    parameter int ZERO_REG_FIXED = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              stall,
    input  logic [RETIRE_WIDTH-1:0]           retire_valid,
    input  logic [RETIRE_WIDTH*5-1:0]         retire_rd_arch,
    input  logic [RETIRE_WIDTH*PHY_WIDTH-1:0] retire_rd_phy,
    output logic                              retire_ready,
    output logic [RETIRE_WIDTH-1:0]           free_valid,
    output logic [RETIRE_WIDTH*PHY_WIDTH-1:0] free_phy,
    output logic [ARCH_REGS*PHY_WIDTH-1:0]    back_rat,
    input  logic                              recover_req,
    output logic                              recover_busy,
    output logic                              recover_valid,
    output logic [$clog2(ARCH_REGS)-1:0]      recover_base,
    output logic [LANES*PHY_WIDTH-1:0]        recover_data,
    output logic                              recover_done
);
    localparam int AW     = $clog2(ARCH_REGS);
    localparam int GROUPS = ARCH_REGS / LANES;
    localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [GW-1:0] LAST_GRP = GW'(GROUPS - 1);

    typedef enum logic [1:0] {IDLE, COPY, DONE} state_t;

    state_t                                  state_q, state_d;
    logic [GW-1:0]                           grp_q, grp_d;
    logic [ARCH_REGS-1:0][PHY_WIDTH-1:0]     map_q, map_next;
    logic [GROUPS-1:0][LANES*PHY_WIDTH-1:0]  map_grp;
    logic [RETIRE_WIDTH-1:0]                 accept, free_en, free_valid_q;
    logic [RETIRE_WIDTH-1:0][PHY_WIDTH-1:0]  old_phy, free_phy_q;
    logic                                    rec_valid, rec_done;

    assign retire_ready = (state_q == IDLE);
    assign accept       = retire_valid & {RETIRE_WIDTH{retire_ready && !stall}};

    for (genvar k = 0; k < RETIRE_WIDTH; k++) begin : g_slot
        logic [ARCH_REGS-1:0][PHY_WIDTH-1:0] map_in, map_out;
        if (k == 0) begin : g_first
            assign map_in = map_q;
        end else begin : g_chain
            assign map_in = g_slot[k-1].map_out;
        end
        arch_rat_slot #(
            .ARCH_REGS      (ARCH_REGS),
            .PHY_WIDTH      (PHY_WIDTH),
            .ZERO_REG_FIXED (ZERO_REG_FIXED)
        ) u_slot (
            .accept  (accept[k]),
            .rd_arch (retire_rd_arch[k*5 +: 5]),
            .rd_phy  (retire_rd_phy[k*PHY_WIDTH +: PHY_WIDTH]),
            .map_in  (map_in),
            .map_out (map_out),
            .free_en (free_en[k]),
            .old_phy (old_phy[k])
        );
    end

    assign map_next = g_slot[RETIRE_WIDTH-1].map_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ARCH_REGS; i++)
                map_q[i] <= PHY_WIDTH'(i);
            free_valid_q <= '0;
            free_phy_q   <= '0;
            state_q      <= IDLE;
            grp_q        <= '0;
        end else begin
            map_q        <= map_next;
            free_valid_q <= free_en;
            for (int k = 0; k < RETIRE_WIDTH; k++)
                if (free_en[k])
                    free_phy_q[k] <= old_phy[k];
            state_q      <= state_d;
            grp_q        <= grp_d;
        end
    end

    // Stall freezes the sequencer in whatever state it is in, including DONE.
    always_comb begin
        state_d   = state_q;
        grp_d     = grp_q;
        rec_valid = 1'b0;
        rec_done  = 1'b0;
        case (state_q)
            IDLE: begin
                if (recover_req && !stall) begin
                    state_d = COPY;
                    grp_d   = '0;
                end
            end
            COPY: begin
                if (!stall) begin
                    rec_valid = 1'b1;
                    if (grp_q == LAST_GRP)
                        state_d = DONE;
                    else
                        grp_d = grp_q + 1'b1;
                end
            end
            DONE: begin
                if (!stall) begin
                    rec_done = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign map_grp       = map_q;
    assign recover_busy  = (state_q != IDLE);
    assign recover_valid = rec_valid;
    assign recover_done  = rec_done;
    assign recover_base  = (state_q == COPY) ? AW'(32'(grp_q) * 32'(LANES)) : '0;
    assign recover_data  = (state_q == COPY) ? map_grp[grp_q] : '0;
    assign free_valid    = free_valid_q;
    assign free_phy      = free_phy_q;
    assign back_rat      = map_q;
endmodule

// File: doc/arch_rat_multi_retire.md
Name: arch_rat_multi_retire

Overview:
- Retirement-side (architectural) register alias table for multi-wide retire.
- Commits up to RETIRE_WIDTH rename mappings per cycle and returns each superseded physical register to the free list.
- Exposes the full committed map as a flat vector.
- On recovery, streams the committed map to the front-end RAT LANES entries per cycle through a small sequencer.

Parameters:
- ARCH_REGS, 32: number of architectural registers; power of two.
- PHY_WIDTH, 6: physical register tag width.
- RETIRE_WIDTH, 2: retire slots per cycle; slot 0 is oldest.
- LANES, 8: map entries streamed per recovery cycle; ARCH_REGS must be a multiple of LANES.
- ZERO_REG_FIXED, 1: when 1, entry 0 is never written and retires to arch reg 0 free nothing.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- stall  in  1  freezes commit and recovery progress
- retire_valid  in  RETIRE_WIDTH  per-slot commit valid
- retire_rd_arch  in  RETIRE_WIDTH*5  per-slot destination arch reg
- retire_rd_phy  in  RETIRE_WIDTH*PHY_WIDTH  per-slot new physical tag
- retire_ready  out  1  high when commits are accepted
- free_valid  out  RETIRE_WIDTH  registered per-slot release valid
- free_phy  out  RETIRE_WIDTH*PHY_WIDTH  registered superseded tags
- back_rat  out  ARCH_REGS*PHY_WIDTH  committed map; entry i at bits [(i+1)*PHY_WIDTH-1 : i*PHY_WIDTH]
- recover_req  in  1  start map streaming (single-cycle pulse)
- recover_busy  out  1  sequencer not in IDLE
- recover_valid  out  1  recover_data carries a valid group
- recover_base  out  $clog2(ARCH_REGS)  first entry index of the group
- recover_data  out  LANES*PHY_WIDTH  entries base..base+LANES-1, lowest entry in the low bits
- recover_done  out  1  one-cycle pulse after the last group

Behaviour:
- Reset (asynchronous):
  - Map entry i = i.
  - free_valid = 0, free_phy = 0.
  - FSM = IDLE; recover_* outputs = 0; retire_ready = 1.
- Commit accepted for slot k when retire_valid[k] && retire_ready && !stall; retire_ready = (FSM==IDLE).
- Same-cycle WAW between slots:
  - Slot k's old tag is the map entry as modified by accepted slots 0..k-1 of the same cycle.
  - The final entry takes the highest accepted slot.
  - Example: slots 0 and 1 both write r5. Slot 1 frees slot 0's new tag; slot 0 frees the pre-cycle entry.
- Free outputs:
  - Registered, 1-cycle latency after the accepting edge.
  - free_valid[k] = 1 for one cycle per accepted slot, except rd_arch==0 when ZERO_REG_FIXED.
  - free_phy holds its last value when free_valid = 0.
- back_rat reflects the map after the clock edge; there is no combinational bypass from retire inputs.
- Stall: no map update, free_valid = 0 next cycle, FSM holds state and recover_valid = 0.
- FSM states and transitions:
  - IDLE: recover_req && !stall → COPY with group index g = 0. Commits accepted in the same cycle as the request are included in the stream.
  - COPY: each non-stalled cycle drives recover_valid = 1, recover_base = g*LANES, and data from the current map, then increments g. After g = ARCH_REGS/LANES-1 → DONE.
  - DONE: recover_done = 1 for one cycle → IDLE.
- recover_req while busy is ignored.
- Retire inputs are ignored while busy: retire_ready = 0, no update, no free.
- The stream is one cycle per group; total busy time is ARCH_REGS/LANES + 1 cycles with no stall (defaults: 4 COPY + 1 DONE).
- Reset mid-stream: everything returns to reset values immediately; no recover_done pulse.

Test Plan:
- Reset → back_rat entry i = i for all 32 entries; retire_ready = 1; free_valid = 0; recover_busy = 0.
- Slot0 retires r3→40 → next cycle free_valid = 01, free_phy slot0 = 3; entry 3 = 40.
- Same cycle: slot0 r5→33, slot1 r5→34 → entry 5 = 34; free slot0 = 5, slot1 = 33, free_valid = 11.
- Retire r0→50 (ZERO_REG_FIXED=1) together with r7→51 → entry 0 = 0, entry 7 = 51; free_valid = 10, free slot1 = 7.
- recover_req pulse in the same cycle as r9→60 → 4 cycles of recover_valid with base 0, 8, 16, 24, group 1 containing 60 at lane 1; then recover_done = 1; retire_ready = 0 for 5 cycles.
- Stall asserted during the second COPY cycle, then rst asserted in the third → group base 8 is held until stall drops; rst clears busy/valid to 0, restores the identity map, and no recover_done pulse occurs.
